// File: rtl/right_shift_register.sv
// Serial-in, parallel-out right shift register: new bit enters at the MSB, oldest bit falls off the LSB.
// Latency: a bit sampled on an enabled edge is visible at out[DEPTH-1] right after that edge.
// Backpressure: none; every enabled edge shifts unconditionally, and enable low holds the contents.
module right_shift_register #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             enable,
    output logic [DEPTH-1:0] out
);

    generate
        if (DEPTH < 2) begin : g_depth_check
            $error("right_shift_register: DEPTH must be at least 2");
        end
    endgenerate

    logic [DEPTH-1:0] q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (enable) begin
            q <= {in, q[DEPTH-1:1]};
        end
    end

    assign out = q;

endmodule

// File: tb/tb_right_shift_register.sv
// Directed bench for right_shift_register at DEPTH=8, checking 1 time unit after each rising edge.
module tb_right_shift_register;

    logic       clk;
    logic       reset;
    logic       in;
    logic       enable;
    logic [7:0] out;

    int checks;
    int failures;

    right_shift_register #(.DEPTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .enable (enable),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive one bit with enable high away from the edge, then check just after the edge.
    task automatic shift_chk(input logic v, input logic [7:0] exp, input string tag);
        @(negedge clk);
        in     = v;
        enable = 1'b1;
        @(posedge clk);
        #1;
        check(tag, out, exp);
    endtask

    task automatic hold_chk(input logic v, input logic [7:0] exp, input string tag);
        @(negedge clk);
        in     = v;
        enable = 1'b0;
        @(posedge clk);
        #1;
        check(tag, out, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        enable   = 1'b1;
        in       = 1'b1;

        // Reset held low across enabled edges with in=1: reset must win.
        @(posedge clk); #1;
        check("rst_edge1", out, 8'b00000000);
        @(posedge clk); #1;
        check("rst_edge2", out, 8'b00000000);
        @(negedge clk);
        in    = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_release", out, 8'b00000000);

        // Alternating input from cleared state.
        shift_chk(1'b1, 8'b10000000, "alt0");
        shift_chk(1'b0, 8'b01000000, "alt1");
        shift_chk(1'b1, 8'b10100000, "alt2");
        shift_chk(1'b0, 8'b01010000, "alt3");

        // Asynchronous reset between edges.
        #2;
        reset = 1'b0;
        #1;
        check("async_rst", out, 8'b00000000);

        // Full sequence after release.
        @(negedge clk);
        reset = 1'b1;
        shift_chk(1'b1, 8'b10000000, "seq0");
        shift_chk(1'b1, 8'b11000000, "seq1");
        shift_chk(1'b0, 8'b01100000, "seq2");
        shift_chk(1'b1, 8'b10110000, "seq3");
        shift_chk(1'b0, 8'b01011000, "seq4");
        shift_chk(1'b1, 8'b10101100, "seq5");
        shift_chk(1'b1, 8'b11010110, "seq6");

        // Enable low holds after the loaded pattern, while in toggles.
        hold_chk(1'b0, 8'b11010110, "hold_load0");
        hold_chk(1'b1, 8'b11010110, "hold_load1");
        hold_chk(1'b0, 8'b11010110, "hold_load2");
        hold_chk(1'b1, 8'b11010110, "hold_load3");
        hold_chk(1'b0, 8'b11010110, "hold_load4");

        // Enable low from a cleared register with in=1.
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hold_chk(1'b1, 8'b00000000, "hold_zero");
        end

        // Overflow: eight ones fill the register, a following zero pushes out the oldest one.
        do_reset();
        shift_chk(1'b1, 8'b10000000, "ovf1");
        shift_chk(1'b1, 8'b11000000, "ovf2");
        shift_chk(1'b1, 8'b11100000, "ovf3");
        shift_chk(1'b1, 8'b11110000, "ovf4");
        shift_chk(1'b1, 8'b11111000, "ovf5");
        shift_chk(1'b1, 8'b11111100, "ovf6");
        shift_chk(1'b1, 8'b11111110, "ovf7");
        shift_chk(1'b1, 8'b11111111, "ovf_full");
        shift_chk(1'b0, 8'b01111111, "ovf_discard");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/right_shift_register.md
# right_shift_register

Serial-in, parallel-out right shift register of parameterizable depth. Each enabled clock edge inserts the serial input bit at the MSB and moves every stored bit one position toward the LSB; the LSB is discarded. It is the base shifting primitive of the shifting library, used for serial-to-parallel conversion and bit-sequence capture. The module is named `right_shift_register`.

## Interface
- `DEPTH`, default 8: number of register stages and the width of `out`. Legal range is ≥ 2; elaboration fails for smaller values.
- `clk`  input  1  single clock; all state updates occur on its rising edge.
- `reset`  input  1  asynchronous, active-low reset. While low, all stages are cleared.
- `in`  input  1  serial data bit, shifted into the MSB.
- `enable`  input  1  shift enable, active-high, synchronous.
- `out`  output  DEPTH  parallel register contents. `out[DEPTH-1]` is the newest bit and `out[0]` is the oldest.

## Operation
- State is a DEPTH-bit register `q`. `out` is driven directly from `q`, with no combinational path from `in` or `enable`.
- When `reset` is low: `q` is 0 immediately and asynchronously, independent of `clk`. It stays 0 as long as `reset` is low, whatever the state of `enable` or `in`.
- Rising `clk`, `reset` high, `enable` high: `q` becomes `{in, q[DEPTH-1:1]}`.
  - `in` goes to bit DEPTH-1.
  - Bit i takes the old bit i+1.
  - Old bit 0 is dropped.
- Rising `clk`, `reset` high, `enable` low: `q` holds its value.
- No overflow or full indication. After DEPTH enabled shifts, `out` holds the last DEPTH input bits, with the most recent at the MSB. Later shifts discard the oldest bit.
- The power-up value of `q` is undefined until the first `reset` assertion. The system must assert `reset` before use.

## Timing
- Latency: a bit sampled on `in` at rising edge N appears at `out[DEPTH-1]` immediately after edge N. It reaches `out[0]` after edge N+DEPTH-1, counting enabled edges only. It leaves the register at the next enabled edge.
- `in` and `enable` are sampled only at the rising edge. Both must meet setup/hold around that edge. Changes between edges have no effect.
- Reset assertion mid-operation: `out` goes to 0 without waiting for a clock edge. Prior contents are lost.
- Reset release: the first edge that can shift is the first rising `clk` with `reset` already high. Deassertion must meet recovery time. The block does not synchronize `reset`.
- If `reset` is low at a rising edge, reset wins regardless of `enable`.
- No handshake: every enabled edge unconditionally shifts.

## Test plan
All scenarios use DEPTH=8 and a 10-time-unit clock period. Checks are made 1 time unit after each rising edge.
- Reset: hold `reset` low with `enable`=1 for two edges, then release → `out`=8'b00000000.
- Alternating input: from cleared state with `enable`=1, apply `in` = 1,0,1,0 on successive edges → `out` = 10000000, 01000000, 10100000, 01010000.
- Async reset mid-stream: from `out`=01010000, pull `reset` low between edges → `out`=00000000 before the next edge.
- Full sequence: release `reset`, then shift `in` = 1,1,0,1,0,1,1 → `out` = 10000000, 11000000, 01100000, 10110000, 01011000, 10101100, 11010110.
- Enable low holds:
  - Reset, then release with `enable`=0 and `in`=1, and clock several edges → `out` stays 00000000.
  - Load 11010110, drop `enable`, toggle `in` for 5 edges → `out` stays 11010110.
- Overflow/discard: clear, then shift 8 ones followed by one 0 → `out` = 11111111, then 01111111.
